ntt_out_fifo: RTL

Elastic first-word-fall-through FIFO on the output side of the NTT/INTT pipeline, with a valid/ready read port for the downstream consumer (poly memory writer, hash/pack unit).
- The NTT pipeline has no stall path, so the write side is push-only. Backpressure goes upstream through `afull`.
- Storage is a separate-address dual-port array: independent write and read pointers, unlike the same-address delay-line FIFOs inside the NTT stages.

---
 rtl/ntt_pkg.sv | 18 +
 rtl/ntt_fifo_ptr.sv | 26 ++
 rtl/ntt_out_fifo.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// ============================================================================
// ntt_pkg : shared NTT constants and word types
// Rev 1.0
// ============================================================================
`default_nettype none

package ntt_pkg;

    localparam int COEF_BITS          = 12;
    localparam int NTT_OUT_FIFO_DEPTH = 16;
    localparam int NTT_OUT_FIFO_AFULL = 4;

    // Two packed Kyber coefficients per output word
    typedef logic [2*COEF_BITS-1:0] ntt_out_word_t;

endpackage

`default_nettype wire

// File: rtl/ntt_fifo_ptr.sv
// ============================================================================
// ntt_fifo_ptr : enabled wrap-around pointer, wraps by natural overflow
// Rev 1.0
// ============================================================================
`default_nettype none

module ntt_fifo_ptr #(
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ntt_out_fifo.sv
// ============================================================================
// ntt_out_fifo : push-only FWFT output FIFO for the NTT pipeline, valid/ready
//                read side. Optional high-watermark via NTT_FIFO_STATS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module ntt_out_fifo
    import ntt_pkg::*;
#(
    parameter int WIDTH    = $bits(ntt_out_word_t),
    parameter int DEPTH    = NTT_OUT_FIFO_DEPTH,
    parameter int AFULL_TH = NTT_OUT_FIFO_AFULL
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       afull,
    output logic                       full,
    output logic                       overflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef NTT_FIFO_STATS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] max_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_AT = CW'(DEPTH - AFULL_TH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push_acc;
    logic          load;
    logic          arr_empty;
    logic          bypass;
    logic          wr_en;
    logic          rd_en;
    logic [CW-1:0] count_nxt;

    // The array never holds more than DEPTH-1 words (one sits in out_data),
    // so pointer equality is an unambiguous empty test.
    assign arr_empty = (wr_ptr == rd_ptr);
    assign pop       = out_valid && out_ready;
    assign push_acc  = in_valid && ((count != DEPTH_C) || pop);
    assign load      = !out_valid || pop;
    assign bypass    = load && arr_empty && push_acc;
    assign wr_en     = push_acc && !bypass;
    assign rd_en     = load && !arr_empty;

    always_comb begin
        count_nxt = count;
        if (push_acc && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push_acc && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    ntt_fifo_ptr #(.PTR_W(AW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_en),
        .ptr   (wr_ptr)
    );

    ntt_fifo_ptr #(.PTR_W(AW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rd_en),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            count     <= '0;
            full      <= 1'b0;
            afull     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (load) begin
                if (!arr_empty) begin
                    out_data  <= mem[rd_ptr];
                    out_valid <= 1'b1;
                end else if (push_acc) begin
                    out_data  <= in_data;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (in_valid && !push_acc) begin
                overflow <= 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            afull <= (count_nxt >= AFULL_AT);
        end
    end

`ifdef NTT_FIFO_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_count <= '0;
        end else if (count > max_count) begin
            max_count <= count;
        end
    end
`endif

endmodule

`default_nettype wire
